mxv_result_collector: RTL and testbench

Downstream stage of the matrix-by-vector engine. Captures each NI-element result word that the decoder presents with its `outsider_read_now` strobe. Zero-fills elements that belong to padding rows, then stores the words in an internal result RAM. Raises `finish` once every expected word for the current product has landed, and exposes a registered random-access read port for the next stage of the solver.

---
 rtl/mxv_pkg.sv | 16 +
 rtl/mxv_result_collector_ram.sv | 38 +++
 rtl/mxv_result_collector.sv | 155 +++++++++++++++
 tb/tb_mxv_result_collector.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mxv_pkg.sv
// Shared definitions for the matrix-by-vector engine: element geometry defaults,
// the padding fill value and the result-collector state encoding.
package mxv_pkg;

  localparam int DEF_ELEMENT_WIDTH = 32;
  localparam int DEF_NI            = 8;

  localparam logic [31:0] ZERO_FILLING = 32'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } collector_state_e;

endpackage

// File: rtl/mxv_result_collector_ram.sv
// Simple dual-port result RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
module collector_ram #(
  parameter int data_width = 256,
  parameter int depth      = 64,
  parameter int addr_width = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [addr_width-1:0] waddr_i,
  input  logic [data_width-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [addr_width-1:0] raddr_i,
  output logic [data_width-1:0] rdata_o
);

  logic [data_width-1:0] mem_q [depth];
  logic [data_width-1:0] rdata_q;

  // Storage array is not reset; only the read register has a defined reset value.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= {data_width{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mxv_result_collector.sv
// Collects decoder result words into the result RAM, zero-filling padding rows
// when MXV_COLLECTOR_ZERO_FILL_EN is defined, and flags completion of a product.
module mxv_result_collector
  import mxv_pkg::*;
#(
  parameter int element_width = DEF_ELEMENT_WIDTH,
  parameter int NI            = DEF_NI,
  parameter int depth         = 64,
  parameter int addr_width    = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NI*element_width-1:0] in_data,
  input  logic                        in_valid,
  input  logic [31:0]                 total_rows,
  input  logic [31:0]                 real_rows,
  input  logic                        rd_en,
  input  logic [addr_width-1:0]       rd_addr,
  output logic [NI*element_width-1:0] rd_data,
  output logic                        rd_valid,
  output logic [addr_width:0]         words_written,
  output logic                        overflow,
  output logic                        finish
);

  localparam int WORD_W = NI * element_width;
  localparam int CNT_W  = addr_width + 1;

  collector_state_e   state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [32:0]        expected_q, expected_d;
  logic               overflow_q, overflow_d;
  logic               finish_q, finish_d;
  logic               rd_valid_q;
  logic               we_s;
  logic [32:0]        e_s;
  logic [WORD_W-1:0]  masked_s;

  assign e_s = ({1'b0, total_rows} + 33'(NI - 1)) / 33'(NI);

`ifdef MXV_COLLECTOR_ZERO_FILL_EN
  always_comb begin
    masked_s = in_data;
    for (int k = 0; k < NI; k++) begin
      if ((33'(count_q) * 33'(NI) + 33'(k)) >= {1'b0, real_rows}) begin
        masked_s[(NI-k)*element_width-1 -: element_width] = element_width'(ZERO_FILLING);
      end else begin
        masked_s[(NI-k)*element_width-1 -: element_width] = in_data[(NI-k)*element_width-1 -: element_width];
      end
    end
  end
`else
  logic unused_real_rows_s;
  assign unused_real_rows_s = ^{real_rows, ZERO_FILLING};
  assign masked_s = in_data;
`endif

  // Dropping start aborts from any state; otherwise strobes outside COLLECT or past depth are dropped.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    expected_d = expected_q;
    overflow_d = overflow_q;
    we_s       = 1'b0;
    if (!start) begin
      state_d    = IDLE;
      count_d    = {CNT_W{1'b0}};
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          expected_d = e_s;
          if (in_valid) begin
            overflow_d = 1'b1;
          end else begin
            overflow_d = overflow_q;
          end
          if (e_s == 33'd0) begin
            state_d = DONE;
          end else begin
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            if (count_q == CNT_W'(depth)) begin
              overflow_d = 1'b1;
            end else begin
              we_s    = 1'b1;
              count_d = count_q + CNT_W'(1);
              if ((33'(count_q) + 33'd1) == expected_q) begin
                state_d = DONE;
              end else begin
                state_d = COLLECT;
              end
            end
          end else begin
            state_d = COLLECT;
          end
        end
        DONE: begin
          if (in_valid) begin
            overflow_d = 1'b1;
          end else begin
            overflow_d = overflow_q;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    finish_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= {CNT_W{1'b0}};
      expected_q <= 33'd0;
      overflow_q <= 1'b0;
      finish_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      expected_q <= expected_d;
      overflow_q <= overflow_d;
      finish_q   <= finish_d;
      rd_valid_q <= rd_en;
    end
  end

  collector_ram #(
    .data_width (WORD_W),
    .depth      (depth),
    .addr_width (addr_width)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (we_s & ~reset),
    .waddr_i (count_q[addr_width-1:0]),
    .wdata_i (masked_s),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign rd_valid      = rd_valid_q;
  assign words_written = count_q;
  assign overflow      = overflow_q;
  assign finish        = finish_q;

endmodule

// File: tb/tb_mxv_result_collector.sv
// Table-driven bench for mxv_result_collector plus hand-written reset and depth sequences.
module tb_mxv_result_collector;

  localparam int EW = 32;
  localparam int NI = 8;
  localparam int DEPTH = 64;
  localparam int AW = 6;
  localparam int WW = EW * NI;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, rd_en;
  logic [WW-1:0] in_data, rd_data;
  logic [31:0]   total_rows, real_rows;
  logic [AW-1:0] rd_addr;
  logic          rd_valid, overflow, finish;
  logic [AW:0]   words_written;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mxv_result_collector #(
    .element_width (EW), .NI (NI), .depth (DEPTH), .addr_width (AW)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .in_data (in_data), .in_valid (in_valid),
    .total_rows (total_rows), .real_rows (real_rows), .rd_en (rd_en), .rd_addr (rd_addr),
    .rd_data (rd_data), .rd_valid (rd_valid), .words_written (words_written),
    .overflow (overflow), .finish (finish)
  );

  typedef struct {
    string         name;
    logic          rst, st, iv;
    logic [WW-1:0] d;
    logic          re;
    logic [AW-1:0] ra;
    logic [31:0]   tr, rr;
    logic          chk_rd;
    logic [WW-1:0] e_rd;
    logic          e_rv;
    logic [AW:0]   e_ww;
    logic          e_ov, e_fin;
  } vec_t;

  vec_t          tbl[$];
  logic [31:0]   cur_tr, cur_rr;
  logic [WW-1:0] zw, ffw, exp_ff;

  function automatic logic [WW-1:0] mk(input logic [31:0] b);
    logic [WW-1:0] w;
    for (int k = 0; k < NI; k++) w[(NI-k)*EW-1 -: EW] = b + 32'(k);
    return w;
  endfunction

  task automatic add(input string nm, input logic rst, input logic st, input logic iv,
                     input logic [WW-1:0] d, input logic re, input logic [AW-1:0] ra,
                     input logic chk, input logic [WW-1:0] erd, input logic erv,
                     input logic [AW:0] eww, input logic eov, input logic efin);
    vec_t v;
    v.name = nm; v.rst = rst; v.st = st; v.iv = iv; v.d = d; v.re = re; v.ra = ra;
    v.tr = cur_tr; v.rr = cur_rr; v.chk_rd = chk; v.e_rd = erd; v.e_rv = erv;
    v.e_ww = eww; v.e_ov = eov; v.e_fin = efin;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic st, input logic iv, input logic [WW-1:0] d,
                       input logic re, input logic [AW-1:0] ra);
    @(negedge clk);
    reset = rst; start = st; in_valid = iv; in_data = d; rd_en = re; rd_addr = ra;
    total_rows = cur_tr; real_rows = cur_rr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic chk, input logic [WW-1:0] erd, input logic erv,
                       input logic [AW:0] eww, input logic eov, input logic efin);
    n_vec++;
    if (rd_valid !== erv || words_written !== eww || overflow !== eov || finish !== efin) begin
      n_err++;
      $display("FAIL %s: rd_valid=%b ww=%0d ovf=%b fin=%b, required rd_valid=%b ww=%0d ovf=%b fin=%b",
               nm, rd_valid, words_written, overflow, finish, erv, eww, eov, efin);
    end
    if (chk && rd_data !== erd) begin
      n_err++;
      $display("FAIL %s rd_data: got %h required %h", nm, rd_data, erd);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_en = 1'b0; rd_addr = '0;
    total_rows = 32'd0; real_rows = 32'd0;
    zw  = '0;
    ffw = '1;
`ifdef MXV_COLLECTOR_ZERO_FILL_EN
    exp_ff = {{5{32'hFFFF_FFFF}}, {3{32'h0000_0000}}};
`else
    exp_ff = {8{32'hFFFF_FFFF}};
`endif

    //   name          rst   st    iv    data                   re    ra     chk   exp rd                 rv    ww     ov    fin
    cur_tr = 32'd24; cur_rr = 32'd24;
    add("reset",      1'b1, 1'b0, 1'b0, zw,                    1'b0, 6'd0,  1'b1, zw,                    1'b0, 7'd0,  1'b0, 1'b0);
    add("p1_start",   1'b0, 1'b1, 1'b0, zw,                    1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd0,  1'b0, 1'b0);
    add("p1_x0",      1'b0, 1'b1, 1'b1, mk(32'h1100_0000),     1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd1,  1'b0, 1'b0);
    add("p1_x1",      1'b0, 1'b1, 1'b1, mk(32'h1100_0010),     1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd2,  1'b0, 1'b0);
    add("p1_x2",      1'b0, 1'b1, 1'b1, mk(32'h1100_0020),     1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd3,  1'b0, 1'b1);
    add("p1_stop",    1'b0, 1'b0, 1'b0, zw,                    1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd0,  1'b0, 1'b0);
    cur_tr = 32'd16; cur_rr = 32'd16;
    add("base_start", 1'b0, 1'b1, 1'b0, zw,                    1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd0,  1'b0, 1'b0);
    add("rbw_old",    1'b0, 1'b1, 1'b1, mk(32'h2200_0000),     1'b1, 6'd0,  1'b1, mk(32'h1100_0000),     1'b1, 7'd1,  1'b0, 1'b0);
    add("rbw_new",    1'b0, 1'b1, 1'b1, mk(32'h2200_0010),     1'b1, 6'd0,  1'b1, mk(32'h2200_0000),     1'b1, 7'd2,  1'b0, 1'b1);
    add("base_rd1",   1'b0, 1'b1, 1'b0, zw,                    1'b1, 6'd1,  1'b1, mk(32'h2200_0010),     1'b1, 7'd2,  1'b0, 1'b1);
    add("ovf_strobe", 1'b0, 1'b1, 1'b1, mk(32'h2200_0030),     1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd2,  1'b1, 1'b1);
    add("ovf_rd2",    1'b0, 1'b1, 1'b0, zw,                    1'b1, 6'd2,  1'b1, mk(32'h1100_0020),     1'b1, 7'd2,  1'b1, 1'b1);
    add("base_stop",  1'b0, 1'b0, 1'b0, zw,                    1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd0,  1'b0, 1'b0);
    cur_tr = 32'd32; cur_rr = 32'd32;
    add("ab_start",   1'b0, 1'b1, 1'b0, zw,                    1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd0,  1'b0, 1'b0);
    add("ab_y0",      1'b0, 1'b1, 1'b1, mk(32'h3300_0000),     1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd1,  1'b0, 1'b0);
    add("ab_drop",    1'b0, 1'b0, 1'b0, zw,                    1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd0,  1'b0, 1'b0);
    add("ab_restart", 1'b0, 1'b1, 1'b0, zw,                    1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd0,  1'b0, 1'b0);
    add("ab_y1",      1'b0, 1'b1, 1'b1, mk(32'h3300_0010),     1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd1,  1'b0, 1'b0);
    add("ab_y2",      1'b0, 1'b1, 1'b1, mk(32'h3300_0020),     1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd2,  1'b0, 1'b0);
    add("ab_y3",      1'b0, 1'b1, 1'b1, mk(32'h3300_0030),     1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd3,  1'b0, 1'b0);
    add("ab_y4",      1'b0, 1'b1, 1'b1, mk(32'h3300_0040),     1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd4,  1'b0, 1'b1);
    add("ab_rd0",     1'b0, 1'b1, 1'b0, zw,                    1'b1, 6'd0,  1'b1, mk(32'h3300_0010),     1'b1, 7'd4,  1'b0, 1'b1);
    add("ab_rd3",     1'b0, 1'b1, 1'b0, zw,                    1'b1, 6'd3,  1'b1, mk(32'h3300_0040),     1'b1, 7'd4,  1'b0, 1'b1);
    add("ab_stop",    1'b0, 1'b0, 1'b0, zw,                    1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd0,  1'b0, 1'b0);
    cur_tr = 32'd16; cur_rr = 32'd13;
    add("zf_start",   1'b0, 1'b1, 1'b0, zw,                    1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd0,  1'b0, 1'b0);
    add("zf_w0",      1'b0, 1'b1, 1'b1, mk(32'h4400_0000),     1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd1,  1'b0, 1'b0);
    add("zf_w1",      1'b0, 1'b1, 1'b1, ffw,                   1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd2,  1'b0, 1'b1);
    add("zf_rd1",     1'b0, 1'b1, 1'b0, zw,                    1'b1, 6'd1,  1'b1, exp_ff,                1'b1, 7'd2,  1'b0, 1'b1);
    add("zf_rd0",     1'b0, 1'b1, 1'b0, zw,                    1'b1, 6'd0,  1'b1, mk(32'h4400_0000),     1'b1, 7'd2,  1'b0, 1'b1);
    cur_tr = 32'd0; cur_rr = 32'd0;
    add("zf_stop",    1'b0, 1'b0, 1'b0, zw,                    1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd0,  1'b0, 1'b0);
    add("e0_start",   1'b0, 1'b1, 1'b0, zw,                    1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd0,  1'b0, 1'b1);
    add("e0_hold",    1'b0, 1'b1, 1'b0, zw,                    1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd0,  1'b0, 1'b1);
    add("e0_stop",    1'b0, 1'b0, 1'b0, zw,                    1'b0, 6'd0,  1'b0, zw,                    1'b0, 7'd0,  1'b0, 1'b0);

    foreach (tbl[i]) begin
      cur_tr = tbl[i].tr; cur_rr = tbl[i].rr;
      drive(tbl[i].rst, tbl[i].st, tbl[i].iv, tbl[i].d, tbl[i].re, tbl[i].ra);
      check(tbl[i].name, tbl[i].chk_rd, tbl[i].e_rd, tbl[i].e_rv, tbl[i].e_ww, tbl[i].e_ov, tbl[i].e_fin);
    end

    // Synchronous reset with a strobe in the same cycle: nothing may be written.
    cur_tr = 32'd16; cur_rr = 32'd16;
    drive(1'b0, 1'b1, 1'b0, zw, 1'b0, 6'd0);
    drive(1'b0, 1'b1, 1'b1, mk(32'h5500_0000), 1'b0, 6'd0);
    check("rst_pre", 1'b0, zw, 1'b0, 7'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, mk(32'h5500_0010), 1'b1, 6'd0);
    check("rst_strobe", 1'b1, zw, 1'b0, 7'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, zw, 1'b1, 6'd1);
    check("rst_nowrite", 1'b1, exp_ff, 1'b1, 7'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, zw, 1'b1, 6'd0);
    check("rst_keep0", 1'b1, mk(32'h5500_0000), 1'b1, 7'd0, 1'b0, 1'b0);

    // Fill the whole RAM with a product larger than depth, then one strobe too many.
    cur_tr = 32'd1000; cur_rr = 32'd1000;
    drive(1'b0, 1'b1, 1'b0, zw, 1'b0, 6'd0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 1'b1, mk(32'h6600_0000 + 32'(i) * 32'h10), 1'b0, 6'd0);
    end
    check("full_64", 1'b0, zw, 1'b0, 7'd64, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, mk(32'h7700_0000), 1'b0, 6'd0);
    check("depth_ovf", 1'b0, zw, 1'b0, 7'd64, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, zw, 1'b1, 6'd63);
    check("full_rd63", 1'b1, mk(32'h6600_03F0), 1'b1, 7'd64, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, zw, 1'b1, 6'd0);
    check("full_rd0", 1'b1, mk(32'h6600_0000), 1'b1, 7'd64, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
